// File: rtl/ps2_kbmat.sv
// rtl/ps2_kbmat.sv - PS/2 Set-2 scancode stream to Z88 64-bit key matrix
//
// Ports:
//   clk        system (Z80) clock
//   reset      synchronous, active-high reset
//   scan_valid one-cycle strobe, scan_code holds a received PS/2 byte
//   scan_code  received PS/2 byte
//   kbmat      key matrix, bit 8*r+c = row r (A8+r), data bit c, 1 = pressed
//   key_change one-cycle pulse whenever kbmat changed
//   any_key    registered OR of kbmat
//   seq_err    sticky timeout / protocol error flag, cleared only by reset
module ps2_kbmat #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_valid,
  input  logic [7:0]  scan_code,
  output logic [63:0] kbmat,
  output logic        key_change,
  output logic        any_key,
  output logic        seq_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [SW-1:0] skip, skip_nxt;
  logic [63:0]   kbmat_nxt;
  logic          seq_err_nxt;
  logic [6:0]    lk;

  // {hit, idx}; row order follows the Z88 matrix, A8 (row 0) first.
  function automatic logic [6:0] keymap(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h066: keymap = {1'b1, 6'd7};   9'h05A: keymap = {1'b1, 6'd6};
      9'h036: keymap = {1'b1, 6'd5};   9'h035: keymap = {1'b1, 6'd4};
      9'h033: keymap = {1'b1, 6'd3};   9'h031: keymap = {1'b1, 6'd2};
      9'h03D: keymap = {1'b1, 6'd1};   9'h03E: keymap = {1'b1, 6'd0};
      9'h05D: keymap = {1'b1, 6'd15};  9'h174: keymap = {1'b1, 6'd14};
      9'h02E: keymap = {1'b1, 6'd13};  9'h02C: keymap = {1'b1, 6'd12};
      9'h034: keymap = {1'b1, 6'd11};  9'h032: keymap = {1'b1, 6'd10};
      9'h03C: keymap = {1'b1, 6'd9};   9'h043: keymap = {1'b1, 6'd8};
      9'h055: keymap = {1'b1, 6'd23};  9'h172: keymap = {1'b1, 6'd22};
      9'h025: keymap = {1'b1, 6'd21};  9'h02D: keymap = {1'b1, 6'd20};
      9'h02B: keymap = {1'b1, 6'd19};  9'h02A: keymap = {1'b1, 6'd18};
      9'h03B: keymap = {1'b1, 6'd17};  9'h044: keymap = {1'b1, 6'd16};
      9'h04E: keymap = {1'b1, 6'd31};  9'h175: keymap = {1'b1, 6'd30};
      9'h026: keymap = {1'b1, 6'd29};  9'h024: keymap = {1'b1, 6'd28};
      9'h023: keymap = {1'b1, 6'd27};  9'h021: keymap = {1'b1, 6'd26};
      9'h042: keymap = {1'b1, 6'd25};  9'h046: keymap = {1'b1, 6'd24};
      9'h05B: keymap = {1'b1, 6'd39};  9'h16B: keymap = {1'b1, 6'd38};
      9'h01E: keymap = {1'b1, 6'd37};  9'h01D: keymap = {1'b1, 6'd36};
      9'h01B: keymap = {1'b1, 6'd35};  9'h022: keymap = {1'b1, 6'd34};
      9'h03A: keymap = {1'b1, 6'd33};  9'h04D: keymap = {1'b1, 6'd32};
      9'h054: keymap = {1'b1, 6'd47};  9'h029: keymap = {1'b1, 6'd46};
      9'h016: keymap = {1'b1, 6'd45};  9'h015: keymap = {1'b1, 6'd44};
      9'h045: keymap = {1'b1, 6'd43};  9'h01A: keymap = {1'b1, 6'd42};
      9'h04B: keymap = {1'b1, 6'd41};  9'h01C: keymap = {1'b1, 6'd40};
      9'h005: keymap = {1'b1, 6'd55};  9'h011: keymap = {1'b1, 6'd54};
      9'h00D: keymap = {1'b1, 6'd53};  9'h014: keymap = {1'b1, 6'd52};
      9'h004: keymap = {1'b1, 6'd51};  9'h041: keymap = {1'b1, 6'd50};
      9'h04C: keymap = {1'b1, 6'd49};  9'h052: keymap = {1'b1, 6'd48};
      9'h059: keymap = {1'b1, 6'd63};  9'h012: keymap = {1'b1, 6'd62};
      9'h076: keymap = {1'b1, 6'd61};  9'h006: keymap = {1'b1, 6'd60};
      9'h058: keymap = {1'b1, 6'd59};  9'h049: keymap = {1'b1, 6'd58};
      9'h04A: keymap = {1'b1, 6'd57};  9'h00E: keymap = {1'b1, 6'd56};
      default: keymap = 7'd0;
    endcase
  endfunction

  always_comb begin
    state_nxt   = state;
    tcnt_nxt    = tcnt;
    skip_nxt    = skip;
    kbmat_nxt   = kbmat;
    seq_err_nxt = seq_err;
    lk          = keymap((state == EXT) || (state == EXT_BRK), scan_code);

    if (scan_valid) begin
      tcnt_nxt = '0;
      case (state)
        IDLE: begin
          case (scan_code)
            8'hE0: state_nxt = EXT;
            8'hF0: state_nxt = BRK;
            8'hE1: begin
              state_nxt = PAUSE;
              skip_nxt  = SW'(PAUSE_SKIP);
            end
            // self-test pass/fail and overrun codes: keyboard state is unknown
            8'hAA, 8'hFC, 8'h00, 8'hFF: kbmat_nxt = '0;
            default: if (lk[6]) kbmat_nxt[lk[5:0]] = 1'b1;
          endcase
        end
        EXT: begin
          case (scan_code)
            8'hF0: state_nxt = EXT_BRK;
            8'hE0: state_nxt = EXT;
            // E0 12 / E0 59 are fake shifts wrapped around cursor keys
            8'h12, 8'h59: state_nxt = IDLE;
            default: begin
              if (lk[6]) kbmat_nxt[lk[5:0]] = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
        BRK, EXT_BRK: begin
          state_nxt = IDLE;
          if (scan_code == 8'hF0) begin
            seq_err_nxt = 1'b1;
          end else if (!((state == EXT_BRK) &&
                         (scan_code == 8'h12 || scan_code == 8'h59))) begin
            if (lk[6]) kbmat_nxt[lk[5:0]] = 1'b0;
          end
        end
        PAUSE: begin
          skip_nxt = skip - 1'b1;
          if (skip <= SW'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      // an abandoned prefix may hide a lost break code, so drop every key
      if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_nxt   = IDLE;
        tcnt_nxt    = '0;
        skip_nxt    = '0;
        seq_err_nxt = 1'b1;
        kbmat_nxt   = '0;
      end else begin
        tcnt_nxt = tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      skip       <= '0;
      kbmat      <= '0;
      key_change <= 1'b0;
      any_key    <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      skip       <= skip_nxt;
      kbmat      <= kbmat_nxt;
      key_change <= (kbmat_nxt != kbmat);
      any_key    <= |kbmat_nxt;
      seq_err    <= seq_err_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_kbmat.sv
// tb/tb_ps2_kbmat.sv - self-checking bench for ps2_kbmat
module tb_ps2_kbmat;
  localparam int TO = 40;
  localparam int PS = 7;
  localparam logic [63:0] B6  = 64'd1 << 6;
  localparam logic [63:0] B30 = 64'd1 << 30;
  localparam logic [63:0] B35 = 64'd1 << 35;
  localparam logic [63:0] B40 = 64'd1 << 40;
  localparam logic [63:0] B62 = 64'd1 << 62;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_valid = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic [63:0] kbmat;
  logic        key_change, any_key, seq_err;
  int          checks = 0;
  int          errors = 0;

  ps2_kbmat #(.TIMEOUT_CYCLES(TO), .PAUSE_SKIP(PS)) dut (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
    .kbmat(kbmat), .key_change(key_change), .any_key(any_key), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Reference model: prefix bytes are queued until a sequence completes,
  // then the whole sequence is interpreted at once.
  logic [63:0] m_mat;
  logic        m_err, m_kc, m_any;
  logic [7:0]  pend[$];
  int          pause_left, idle;
  int          km[int];

  function automatic void mdl_reset();
    m_mat = '0; m_err = 0; m_kc = 0; m_any = 0;
    pend.delete(); pause_left = 0; idle = 0;
  endfunction

  function automatic void mdl_apply(bit make, logic [7:0] c, bit ext);
    int k = (ext ? 256 : 0) + int'(c);
    if (km.exists(k)) m_mat[km[k]] = make;
  endfunction

  function automatic void mdl_byte(logic [7:0] b);
    bit ext, brk;
    idle = 0;
    if (pause_left > 0) begin pause_left--; return; end
    if (pend.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
      else if (b == 8'hE1) pause_left = PS;
      else if (b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF) m_mat = '0;
      else mdl_apply(1, b, 0);
      return;
    end
    ext = (pend[0] == 8'hE0);
    brk = (pend[pend.size()-1] == 8'hF0);
    if (b == 8'hF0) begin
      if (brk) begin m_err = 1; pend.delete(); end
      else pend.push_back(b);
    end else if (b == 8'hE0 && ext && !brk) begin
      // repeated E0 keeps the extended prefix
    end else begin
      if (!(ext && (b == 8'h12 || b == 8'h59))) mdl_apply(!brk, b, ext);
      pend.delete();
    end
  endfunction

  function automatic void mdl_cycle(bit v, logic [7:0] c);
    logic [63:0] old = m_mat;
    if (v) mdl_byte(c);
    else if (pend.size() != 0 || pause_left != 0) begin
      idle++;
      if (idle == TO) begin
        pend.delete(); pause_left = 0; idle = 0; m_err = 1; m_mat = '0;
      end
    end
    m_kc  = (m_mat != old);
    m_any = |m_mat;
  endfunction

  task automatic step(input bit v, input logic [7:0] c, input bit r);
    @(negedge clk);
    reset = r; scan_valid = v; scan_code = c;
    @(posedge clk);
    #1;
    if (r) mdl_reset(); else mdl_cycle(v, c);
  endtask

  task automatic test_reset();
    step(0, 8'h00, 1); step(0, 8'h00, 1);
    checks++; if (kbmat !== 64'd0) begin errors++; $display("FAIL rst_kbmat got %h want 0", kbmat); end
    checks++; if (key_change !== 1'b0) begin errors++; $display("FAIL rst_key_change got %b want 0", key_change); end
    checks++; if (any_key !== 1'b0) begin errors++; $display("FAIL rst_any_key got %b want 0", any_key); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL rst_seq_err got %b want 0", seq_err); end
    step(0, 8'h00, 0);
  endtask

  task automatic test_make_break();
    step(1, 8'h1C, 0);
    checks++; if (kbmat !== B40) begin errors++; $display("FAIL mb_make got %h want %h", kbmat, B40); end
    checks++; if (key_change !== 1'b1) begin errors++; $display("FAIL mb_make_kc got %b want 1", key_change); end
    checks++; if (any_key !== 1'b1) begin errors++; $display("FAIL mb_any got %b want 1", any_key); end
    step(0, 8'h00, 0);
    checks++; if (key_change !== 1'b0) begin errors++; $display("FAIL mb_kc_pulse got %b want 0", key_change); end
    step(1, 8'hF0, 0);
    checks++; if (kbmat !== B40 || key_change !== 1'b0) begin errors++; $display("FAIL mb_prefix got %h/%b want %h/0", kbmat, key_change, B40); end
    step(1, 8'h1C, 0);
    checks++; if (kbmat !== 64'd0) begin errors++; $display("FAIL mb_break got %h want 0", kbmat); end
    checks++; if (key_change !== 1'b1 || any_key !== 1'b0) begin errors++; $display("FAIL mb_break_flags got %b/%b want 1/0", key_change, any_key); end
  endtask

  task automatic test_typematic();
    logic [7:0] seq[4] = '{8'h12, 8'h1C, 8'h1C, 8'h1C};
    logic       kcx[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(1, seq[i], 0);
      checks++; if (key_change !== kcx[i]) begin errors++; $display("FAIL typ_kc%0d got %b want %b", i, key_change, kcx[i]); end
    end
    checks++; if (kbmat !== (B62 | B40)) begin errors++; $display("FAIL typ_held got %h want %h", kbmat, B62 | B40); end
    step(1, 8'hF0, 0); step(1, 8'h12, 0);
    checks++; if (kbmat !== B40) begin errors++; $display("FAIL typ_release got %h want %h", kbmat, B40); end
    step(1, 8'hF0, 0); step(1, 8'h1C, 0);
  endtask

  task automatic test_extended();
    step(1, 8'hE0, 0); step(1, 8'h75, 0);
    checks++; if (kbmat !== B30 || key_change !== 1'b1) begin errors++; $display("FAIL ext_make got %h/%b want %h/1", kbmat, key_change, B30); end
    step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h75, 0);
    checks++; if (kbmat !== 64'd0) begin errors++; $display("FAIL ext_break got %h want 0", kbmat); end
    step(1, 8'hE0, 0); step(1, 8'h12, 0);
    checks++; if (kbmat !== 64'd0 || key_change !== 1'b0) begin errors++; $display("FAIL ext_fake_shift got %h/%b want 0/0", kbmat, key_change); end
    step(1, 8'hE0, 0); step(1, 8'h75, 0);
    checks++; if (kbmat !== B30) begin errors++; $display("FAIL ext_after_fake got %h want %h", kbmat, B30); end
    step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h12, 0);
    checks++; if (kbmat !== B30) begin errors++; $display("FAIL ext_fake_break got %h want %h", kbmat, B30); end
    step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h75, 0);
    step(1, 8'hE0, 0); step(1, 8'hE0, 0); step(1, 8'h75, 0);
    checks++; if (kbmat !== B30) begin errors++; $display("FAIL ext_double_e0 got %h want %h", kbmat, B30); end
    step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h75, 0);
  endtask

  task automatic test_pause();
    logic [7:0] seq[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) begin
      step(1, seq[i], 0);
      checks++; if (kbmat !== 64'd0 || key_change !== 1'b0) begin errors++; $display("FAIL pause_byte%0d got %h/%b want 0/0", i, kbmat, key_change); end
    end
    step(1, 8'h1B, 0);
    checks++; if (kbmat !== B35 || key_change !== 1'b1) begin errors++; $display("FAIL pause_after got %h/%b want %h/1", kbmat, key_change, B35); end
    step(1, 8'hF0, 0); step(1, 8'h1B, 0);
  endtask

  task automatic test_clear_timeout();
    step(1, 8'h1C, 0); step(1, 8'h5A, 0);
    checks++; if (kbmat !== (B40 | B6)) begin errors++; $display("FAIL clr_held got %h want %h", kbmat, B40 | B6); end
    step(1, 8'hAA, 0);
    checks++; if (kbmat !== 64'd0 || key_change !== 1'b1 || seq_err !== 1'b0) begin errors++; $display("FAIL clr_aa got %h/%b/%b want 0/1/0", kbmat, key_change, seq_err); end
    step(1, 8'hAA, 0);
    checks++; if (key_change !== 1'b0) begin errors++; $display("FAIL clr_empty_kc got %b want 0", key_change); end
    step(1, 8'h1B, 0); step(1, 8'hF0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 0);
    checks++; if (seq_err !== 1'b0 || kbmat !== B35) begin errors++; $display("FAIL to_early got %b/%h want 0/%h", seq_err, kbmat, B35); end
    step(0, 8'h00, 0);
    checks++; if (seq_err !== 1'b1 || kbmat !== 64'd0 || key_change !== 1'b1) begin errors++; $display("FAIL to_fire got %b/%h/%b want 1/0/1", seq_err, kbmat, key_change); end
    step(1, 8'h1C, 0);
    checks++; if (kbmat !== B40) begin errors++; $display("FAIL to_idle_make got %h want %h", kbmat, B40); end
    step(1, 8'hF0, 0); step(1, 8'h1C, 0);
  endtask

  task automatic test_reset_priority();
    step(1, 8'h5A, 0);
    checks++; if (kbmat !== B6) begin errors++; $display("FAIL rp_hold got %h want %h", kbmat, B6); end
    step(1, 8'h1C, 1);
    checks++; if (kbmat !== 64'd0 || seq_err !== 1'b0 || key_change !== 1'b0) begin errors++; $display("FAIL rp_reset got %h/%b/%b want 0/0/0", kbmat, seq_err, key_change); end
    step(1, 8'hF0, 0); step(1, 8'hF0, 0);
    checks++; if (seq_err !== 1'b1 || kbmat !== 64'd0) begin errors++; $display("FAIL rp_f0f0 got %b/%h want 1/0", seq_err, kbmat); end
    step(1, 8'h5A, 0); step(1, 8'hF0, 0); step(1, 8'hF0, 0);
    checks++; if (kbmat !== B6 || key_change !== 1'b0) begin errors++; $display("FAIL rp_f0f0_held got %h/%b want %h/0", kbmat, key_change, B6); end
    step(1, 8'h1C, 0);
    checks++; if (kbmat !== (B6 | B40)) begin errors++; $display("FAIL rp_idle_after got %h want %h", kbmat, B6 | B40); end
  endtask

  task automatic test_unmapped();
    step(1, 8'h7E, 0);
    checks++; if (kbmat !== (B6 | B40) || key_change !== 1'b0) begin errors++; $display("FAIL um_plain got %h/%b want %h/0", kbmat, key_change, B6 | B40); end
    step(1, 8'hE0, 0); step(1, 8'h1C, 0);
    checks++; if (kbmat !== (B6 | B40) || key_change !== 1'b0) begin errors++; $display("FAIL um_ext got %h/%b want %h/0", kbmat, key_change, B6 | B40); end
  endtask

  task automatic test_random();
    logic [7:0] pool[11] = '{8'h1C, 8'h1B, 8'h5A, 8'h66, 8'h76, 8'h12, 8'h59, 8'h75, 8'h72, 8'h7E, 8'h77};
    int         quiet = 0;
    bit         v;
    logic [7:0] c;
    int         r;
    step(0, 8'h00, 1);
    for (int n = 0; n < 5000; n++) begin
      v = 0; c = 8'h00;
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 299) == 0) quiet = TO + 3;
      else if ($urandom_range(0, 9) < 6) begin
        v = 1;
        r = int'($urandom_range(0, 99));
        if (r < 10) c = 8'hE0;
        else if (r < 22) c = 8'hF0;
        else if (r < 24) c = 8'hE1;
        else if (r < 26) c = 8'hAA;
        else if (r < 27) c = 8'hFC;
        else c = pool[$urandom_range(0, 10)];
      end
      step(v, c, 0);
      checks++; if (kbmat !== m_mat) begin errors++; $display("FAIL rnd_kbmat@%0d got %h want %h", n, kbmat, m_mat); end
      checks++; if (key_change !== m_kc) begin errors++; $display("FAIL rnd_kc@%0d got %b want %b", n, key_change, m_kc); end
      checks++; if (any_key !== m_any) begin errors++; $display("FAIL rnd_any@%0d got %b want %b", n, any_key, m_any); end
      checks++; if (seq_err !== m_err) begin errors++; $display("FAIL rnd_err@%0d got %b want %b", n, seq_err, m_err); end
    end
  endtask

  initial begin
    km[9'h01C] = 40; km[9'h01B] = 35; km[9'h05A] = 6;
    km[9'h012] = 62; km[9'h059] = 63; km[9'h175] = 30;
    km[9'h172] = 22; km[9'h066] = 7;  km[9'h076] = 61;
    mdl_reset();
    test_reset();
    test_make_break();
    test_typematic();
    test_extended();
    test_pause();
    test_clear_timeout();
    test_reset_priority();
    test_unmapped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_kbmat.md
Name: ps2_kbmat

Overview:
- Converts the PS/2 Set-2 scancode byte stream from the PS/2 byte receiver into the 64-bit Z88 key matrix that the Blink keyboard port (IO $B2) reads.
- Tracks break (F0) and extended (E0) prefixes and swallows the Pause (E1) sequence.
- Clears stale key state on keyboard self-test, on error codes, and when a prefix is abandoned.
- Sits directly upstream of the Blink keyboard read logic; its output `kbmat` is consumed unchanged.

Parameters:
- TIMEOUT_CYCLES, 2000000, clocks a pending prefix may wait for its next byte before being abandoned (about 0.5 s at 4 MHz).
- PAUSE_SKIP, 7, bytes discarded after an E1 prefix.

Ports:
- clk  in  1  system clock (Z80 clock)
- reset  in  1  synchronous, active-high reset
- scan_valid  in  1  one-cycle strobe; scan_code is valid
- scan_code  in  8  received PS/2 byte
- kbmat  out  64  key matrix; bit 8*r+c = row r (address line A8+r), data bit c; 1 = pressed
- key_change  out  1  one-cycle pulse when kbmat changed (feeds the Blink KEY interrupt)
- any_key  out  1  OR-reduction of kbmat, registered
- seq_err  out  1  sticky flag: timeout or protocol error since reset; cleared only by reset

Behaviour:
- Reset (sampled on clk rising edge while reset=1): kbmat=0, key_change=0, any_key=0, seq_err=0, state=IDLE, timeout counter=0, skip counter=0. Reset has priority over a simultaneous scan_valid; that byte is lost.
- Bytes are processed only on cycles where scan_valid=1. Back-to-back strobes on consecutive cycles are all accepted.
- States:
  - IDLE: E0→EXT; F0→BRK; E1→PAUSE (skip=PAUSE_SKIP); AA, FC, 00 or FF→clear kbmat; other codes→make(code, ext=0).
  - EXT: F0→EXT_BRK; 12 or 59 (fake shifts)→IDLE, no change; other codes→make(code, ext=1), then IDLE.
  - BRK: any code→break(code, ext=0), then IDLE.
  - EXT_BRK: 12 or 59→IDLE, no change; other codes→break(code, ext=1), then IDLE.
  - PAUSE: each byte decrements skip; reaching 0→IDLE. kbmat is untouched.
- Prefix errors:
  - F0 received in BRK or EXT_BRK: set seq_err, go to IDLE, no matrix change.
  - E0 received in EXT: stay in EXT.
- Timeout: in any state other than IDLE the counter increments every cycle without scan_valid and is zeroed on scan_valid. When it reaches TIMEOUT_CYCLES-1: go to IDLE, set seq_err, clear kbmat. This releases keys whose break code was half-received.
- make/break: a combinational lookup maps (ext, code) to {hit, idx[5:0]}.
  - hit=0: ignored, no change.
  - make: kbmat[idx] set to 1. break: kbmat[idx] set to 0.
- Keymap entries used by the test plan (non-extended unless marked):
  - 1C (A) → idx 40; 1B (S) → idx 35; 5A (Enter) → idx 6
  - 12 (LShift) → idx 62; 59 (RShift) → idx 63
  - E0 75 (Up) → idx 30; E0 72 (Down) → idx 22
  - 66 (Backspace) → idx 7; 76 (Esc) → idx 61
  - Remaining entries follow the Z88 keyboard matrix table in the team's keymap document. Codes not in that table are unmapped.
- Latency: kbmat, any_key and key_change update on the clock edge that samples the final byte of a sequence; they are visible the following cycle.
- key_change=1 only if the new kbmat differs from the old: a repeated make of a held key (typematic) gives no pulse. Clear-all from an empty matrix gives no pulse.
- Multiple keys may be held simultaneously; there is no ghosting logic and no limit.
- seq_err and kbmat clearing are independent: AA clears kbmat but does not set seq_err.

Test Plan:
- Reset, then 1C → kbmat = 1<<40, key_change pulses 1 cycle, any_key=1. Then F0 1C → kbmat=0, key_change pulses, any_key=0.
- 12, 1C, 1C, 1C (typematic) → kbmat bits 62 and 40 set; key_change pulses only for the first 12 and the first 1C. Then F0 12 → only bit 40 remains.
- E0 75 then E0 F0 75 → bit 30 set then cleared. E0 12 E0 75 (fake shift) → only bit 30 set, bit 62 clear.
- E1 14 77 E1 F0 14 F0 77 followed by 1B → kbmat = 1<<35 only, no pulse during the Pause bytes.
- Hold 1C and 5A, send AA → kbmat=0, key_change pulse, seq_err=0. Send F0 then idle TIMEOUT_CYCLES cycles → state IDLE, seq_err=1. A following 1C sets bit 40 (a make, not a break).
- Assert reset on the same cycle as scan_valid with 1C while bit 6 is held → kbmat=0, byte ignored. Next cycle send F0 F0 → seq_err=1, kbmat unchanged.
